quad_decoder_counter: RTL and testbench

//   Quadrature (A/B) decoder with an integrated up/down position counter.

---
 rtl/quad_decoder_counter.sv | 125 ++++++++++++
 tb/tb_quad_decoder_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder with N-bit loadable up/down position counter and sticky phase-error flag.
// Latency: a pin change captured at edge k updates count/step/dir at edge k+SYNC_STAGES.
// Backpressure: none; every legal edge is counted as it arrives, and load overrides a coincident step.
module quad_decoder_counter #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         a,
  input  logic         b,
  input  logic         load,
  input  logic [N-1:0] data,
  output logic [N-1:0] count,
  output logic         dir,
  output logic         step,
  output logic         wraparound,
  output logic         err
);

  // Priming counter must hold SYNC_STAGES+1.
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_INIT = PW'(SYNC_STAGES + 1);
  localparam logic [N-1:0]  CNT_ONE    = {{(N-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             prev_ab_q, prev_ab_d;
  logic [PW-1:0]          prime_q, prime_d;
  logic [N-1:0]           count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   wrap_q, wrap_d;
  logic                   err_q, err_d;

  logic [1:0]             cur_ab;
  logic [1:0]             delta;

  // Map the Gray-coded pair onto its position in the up cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Synchronizer shift chains: bit 0 samples the pin, the top bit feeds the decoder.
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b};
  end

  // Decode the phase step and compute next count / flags; load wins over a step.
  always_comb begin
    cur_ab    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    // Position difference mod 4: 1 = up, 3 = down, 2 = illegal jump, 0 = idle.
    delta     = gray_pos(cur_ab) - gray_pos(prev_ab_q);
    count_d   = count_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    err_d     = err_q;
    // prev_ab always follows the synced pins, so a step discarded by load is lost, not deferred.
    prev_ab_d = cur_ab;
    prime_d   = prime_q;

    if (prime_q != '0) begin
      prime_d = prime_q - PW'(1);
    end

    if (load) begin
      count_d = data;
      err_d   = 1'b0;
    end else if (prime_q == '0) begin
      unique case (delta)
        2'd1: begin
          count_d = count_q + CNT_ONE;
          dir_d   = 1'b1;
          step_d  = 1'b1;
          wrap_d  = (count_q == '1);
        end
        2'd3: begin
          count_d = count_q - CNT_ONE;
          dir_d   = 1'b0;
          step_d  = 1'b1;
          wrap_d  = (count_q == '0);
        end
        2'd2: begin
          err_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset restarts the priming window.
  always_ff @(posedge clk) begin
    if (srst) begin
      a_sync_q  <= '0;
      b_sync_q  <= '0;
      prev_ab_q <= '0;
      prime_q   <= PRIME_INIT;
      count_q   <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      a_sync_q  <= a_sync_d;
      b_sync_q  <= b_sync_d;
      prev_ab_q <= prev_ab_d;
      prime_q   <= prime_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign count      = count_q;
  assign dir        = dir_q;
  assign step       = step_q;
  assign wraparound = wrap_q;
  assign err        = err_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter (N=8, SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_quad_decoder_counter;

  logic       clk = 1'b0;
  logic       srst;
  logic       a;
  logic       b;
  logic       load;
  logic [7:0] data;
  logic [7:0] count;
  logic       dir;
  logic       step;
  logic       wraparound;
  logic       err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  quad_decoder_counter #(.N(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .srst       (srst),
    .a          (a),
    .b          (b),
    .load       (load),
    .data       (data),
    .count      (count),
    .dir        (dir),
    .step       (step),
    .wraparound (wraparound),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic [1:0] ab);
    a = ab[1];
    b = ab[0];
  endtask

  // Reset with the given pins, run the 3 priming cycles plus one settle cycle.
  task automatic reset_at(input logic [1:0] ab);
    set_pins(ab);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    logic step_seen;
    set_pins(2'b11);
    load = 1'b0;
    data = 8'h00;
    srst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({count, dir, step, wraparound, err} !== 12'h000)
      $display("FAIL reset_state: got cnt=%h dir=%b step=%b wrap=%b err=%b, want all zero",
               count, dir, step, wraparound, err);
    else pass_cnt++;
    srst = 1'b0;
    step_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step !== 1'b0) step_seen = 1'b1;
    end
    total_cnt++;
    if (step_seen !== 1'b0) $display("FAIL prime_high_step: step pulsed, want none");
    else pass_cnt++;
    total_cnt++;
    if (count !== 8'h00) $display("FAIL prime_high_count: got %h want 00", count);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL prime_high_err: got %b want 0", err);
    else pass_cnt++;
  endtask

  task automatic test_up_sequence();
    logic [1:0] seq [4];
    int         nsteps;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    reset_at(2'b00);
    nsteps = 0;
    for (int i = 0; i < 4; i++) begin
      set_pins(seq[i]);
      tick();
      if (step === 1'b1) nsteps++;
      tick();
      if (step === 1'b1) nsteps++;
      total_cnt++;
      if (count !== 8'(i)) $display("FAIL up_early_%0d: got %h want %h", i, count, 8'(i));
      else pass_cnt++;
      tick();
      if (step === 1'b1) nsteps++;
      total_cnt++;
      if (count !== 8'(i + 1) || step !== 1'b1 || dir !== 1'b1)
        $display("FAIL up_step_%0d: got cnt=%h step=%b dir=%b want cnt=%h step=1 dir=1",
                 i, count, step, dir, 8'(i + 1));
      else pass_cnt++;
      tick();
      if (step === 1'b1) nsteps++;
    end
    total_cnt++;
    if (nsteps !== 4) $display("FAIL up_pulses: got %0d want 4", nsteps);
    else pass_cnt++;
  endtask

  task automatic test_down_wrap();
    reset_at(2'b00);
    set_pins(2'b10);
    repeat (3) tick();
    total_cnt++;
    if (count !== 8'hFF || dir !== 1'b0 || step !== 1'b1 || wraparound !== 1'b1)
      $display("FAIL down_wrap: got cnt=%h dir=%b step=%b wrap=%b want FF 0 1 1",
               count, dir, step, wraparound);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wraparound !== 1'b0 || step !== 1'b0)
      $display("FAIL down_wrap_pulse: got wrap=%b step=%b want 0 0", wraparound, step);
    else pass_cnt++;
  endtask

  task automatic test_err_load();
    set_pins(2'b00);
    repeat (3) tick();
    total_cnt++;
    if (count !== 8'h00 || wraparound !== 1'b1 || dir !== 1'b1)
      $display("FAIL up_wrap: got cnt=%h wrap=%b dir=%b want 00 1 1", count, wraparound, dir);
    else pass_cnt++;
    tick();
    set_pins(2'b11);
    repeat (3) tick();
    total_cnt++;
    if (err !== 1'b1 || count !== 8'h00 || step !== 1'b0)
      $display("FAIL illegal: got err=%b cnt=%h step=%b want 1 00 0", err, count, step);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else pass_cnt++;
    load = 1'b1;
    data = 8'h5A;
    tick();
    load = 1'b0;
    total_cnt++;
    if (count !== 8'h5A || err !== 1'b0 || dir !== 1'b1 || step !== 1'b0)
      $display("FAIL load_5a: got cnt=%h err=%b dir=%b step=%b want 5A 0 1 0",
               count, err, dir, step);
    else pass_cnt++;
  endtask

  task automatic test_load_vs_step();
    set_pins(2'b10);
    tick();
    tick();
    load = 1'b1;
    data = 8'h10;
    tick();
    load = 1'b0;
    total_cnt++;
    if (count !== 8'h10 || step !== 1'b0 || wraparound !== 1'b0)
      $display("FAIL load_priority: got cnt=%h step=%b wrap=%b want 10 0 0",
               count, step, wraparound);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if (count !== 8'h10 || step !== 1'b0)
      $display("FAIL load_discard: got cnt=%h step=%b want 10 0", count, step);
    else pass_cnt++;
    set_pins(2'b00);
    repeat (3) tick();
    total_cnt++;
    if (count !== 8'h11 || step !== 1'b1)
      $display("FAIL after_load_step: got cnt=%h step=%b want 11 1", count, step);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [1:0] toggles [3];
    toggles[0] = 2'b00; toggles[1] = 2'b01; toggles[2] = 2'b11;
    load = 1'b1;
    data = 8'h03;
    tick();
    load = 1'b0;
    set_pins(2'b11);
    repeat (3) tick();
    total_cnt++;
    if (count !== 8'h03 || err !== 1'b1)
      $display("FAIL pre_reset: got cnt=%h err=%b want 03 1", count, err);
    else pass_cnt++;
    set_pins(2'b10);
    srst = 1'b1;
    load = 1'b1;
    data = 8'h77;
    tick();
    srst = 1'b0;
    load = 1'b0;
    total_cnt++;
    if (count !== 8'h00 || err !== 1'b0 || step !== 1'b0 || wraparound !== 1'b0)
      $display("FAIL mid_reset: got cnt=%h err=%b step=%b wrap=%b want 00 0 0 0",
               count, err, step, wraparound);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      set_pins(toggles[i]);
      tick();
      total_cnt++;
      if (step !== 1'b0 || count !== 8'h00 || err !== 1'b0)
        $display("FAIL prime_%0d: got step=%b cnt=%h err=%b want 0 00 0", i, step, count, err);
      else pass_cnt++;
    end
  endtask

  initial begin
    srst = 1'b1;
    load = 1'b0;
    data = 8'h00;
    a    = 1'b0;
    b    = 1'b0;
    test_reset();
    test_up_sequence();
    test_down_wrap();
    test_err_load();
    test_load_vs_step();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
